axioma_data_mem: RTL and testbench

// - Responder (target) side of the CPU data-memory bus: accepts read/write strobes from the CPU, decodes the address and serves the request.
// - Served targets: internal 2 KB SRAM, or a forwarded I/O bus for peripherals.
// - Returns data with a one-cycle mem_ready pulse after a fixed, parameterised latency.
// - Sits between axioma_cpu's data port and the SRAM/peripheral fabric of the AxiomaCore-328 top level.

---
 rtl/axioma_data_mem_pkg.sv | 25 ++
 rtl/axioma_data_mem_if.sv | 29 ++
 rtl/axioma_sram_bank.sv | 26 ++
 rtl/axioma_data_mem.sv | 181 ++++++++++++++++++
 tb/tb_axioma_data_mem.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axioma_data_mem_pkg.sv
// rtl/axioma_data_mem_pkg.sv - address map, FSM states and decode helper for the data-memory responder
package axioma_data_mem_pkg;

  // Default address map shared with the CPU and peripheral fabric
  localparam logic [15:0] IO_BASE_DEF   = 16'h0020;
  localparam logic [15:0] IO_TOP_DEF    = 16'h00FF;
  localparam logic [15:0] SRAM_BASE_DEF = 16'h0100;
  localparam int          SRAM_SIZE_DEF = 2048;

  // Transaction sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Half-open range test; 17-bit operands so the top bound never wraps
  function automatic logic in_range(input logic [16:0] a,
                                    input logic [16:0] lo,
                                    input logic [16:0] hi_excl);
    return (a >= lo) && (a < hi_excl);
  endfunction

endpackage

// File: rtl/axioma_data_mem_if.sv
// rtl/axioma_data_mem_if.sv - CPU data bus and forwarded I/O bus seen by the responder
interface axioma_data_mem_if;

  // CPU side
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  // Peripheral side
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_read;
  logic        io_write;
  logic [7:0]  io_rdata;

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write, io_rdata,
    output mem_rdata, mem_ready, io_addr, io_wdata, io_read, io_write
  );

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write, io_rdata,
    input  mem_rdata, mem_ready, io_addr, io_wdata, io_read, io_write
  );

endinterface

// File: rtl/axioma_sram_bank.sv
// rtl/axioma_sram_bank.sv - single-port synchronous byte RAM with registered read data
module axioma_sram_bank #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_array [DEPTH];

  // Array write and read-data register; read data only moves on a read so it holds between reads
  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem_array[addr];
    end
  end

endmodule

// File: rtl/axioma_data_mem.sv
// rtl/axioma_data_mem.sv - CPU data-memory responder: decode, SRAM/I-O access, fixed-latency ready
module axioma_data_mem
  import axioma_data_mem_pkg::*;
#(
  parameter logic [15:0] IO_BASE     = IO_BASE_DEF,
  parameter logic [15:0] IO_TOP      = IO_TOP_DEF,
  parameter logic [15:0] SRAM_BASE   = SRAM_BASE_DEF,
  parameter int          SRAM_SIZE   = SRAM_SIZE_DEF,
  parameter int          WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  axioma_data_mem_if.slave  bus,
  output logic              busy,
  input  logic              err_clr,
  output logic              err_unmapped,
  output logic              err_overrun
);

  localparam int         AW = $clog2(SRAM_SIZE);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          op_write_q;

  logic          strobe;
  logic          start;
  logic          in_access;
  logic          hit_io;
  logic          hit_sram;
  logic          unmapped;
  logic          io_sel;

  logic [AW-1:0] sram_idx;
  logic          sram_we;
  logic          sram_re;
  logic [7:0]    sram_rdata;

  logic [7:0]    rdata_q;
  logic          rd_sram_q;
  logic          set_overrun;
  logic          set_unmapped;

  assign strobe    = bus.mem_read | bus.mem_write;
  assign start     = (state_q == ST_IDLE) && strobe;
  assign in_access = (state_q == ST_ACCESS);

  // Decode always looks at the latched address, never the live bus
  assign hit_io   = in_range({1'b0, addr_q}, {1'b0, IO_BASE}, {1'b0, IO_TOP} + 17'd1);
  assign hit_sram = !hit_io &&
                    in_range({1'b0, addr_q}, {1'b0, SRAM_BASE},
                             {1'b0, SRAM_BASE} + 17'(SRAM_SIZE));
  assign unmapped = !hit_io && !hit_sram;

  // Offset arithmetic modulo the bank size is exact once the range check has passed
  assign sram_idx = addr_q[AW-1:0] - SRAM_BASE[AW-1:0];
  assign sram_we  = in_access && hit_sram && op_write_q;
  assign sram_re  = in_access && hit_sram && !op_write_q;

  axioma_sram_bank #(
    .DEPTH (SRAM_SIZE),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .we    (sram_we),
    .re    (sram_re),
    .addr  (sram_idx),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  // State register and wait-state counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: ACCESS is always one cycle, WAIT lasts exactly WS cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (WS == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WS - 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture; a simultaneous read+write is treated as a write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      op_write_q <= 1'b0;
    end else if (start) begin
      addr_q     <= bus.mem_addr;
      wdata_q    <= bus.mem_wdata;
      op_write_q <= bus.mem_write;
    end
  end

  // Read-data source: SRAM data arrives from the bank register, I/O and unmapped data are held here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q   <= 8'h00;
      rd_sram_q <= 1'b0;
    end else if (in_access && !op_write_q) begin
      if (hit_sram) begin
        rd_sram_q <= 1'b1;
      end else begin
        rd_sram_q <= 1'b0;
        rdata_q   <= hit_io ? bus.io_rdata : 8'h00;
      end
    end
  end

  assign set_overrun  = (start && bus.mem_read && bus.mem_write) ||
                        ((state_q != ST_IDLE) && strobe);
  assign set_unmapped = in_access && unmapped;

  // Sticky error flags; a clear wins over a set in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_unmapped <= 1'b0;
      err_overrun  <= 1'b0;
    end else if (err_clr) begin
      err_unmapped <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (set_unmapped) begin
        err_unmapped <= 1'b1;
      end
      if (set_overrun) begin
        err_overrun <= 1'b1;
      end
    end
  end

  // Outputs decode straight from registered state so reset clears them without waiting for an edge
  assign io_sel        = in_access && hit_io;
  assign busy          = (state_q != ST_IDLE);
  assign bus.mem_ready = (state_q == ST_RESP);
  assign bus.mem_rdata = rd_sram_q ? sram_rdata : rdata_q;
  assign bus.io_read   = io_sel && !op_write_q;
  assign bus.io_write  = io_sel && op_write_q;
  assign bus.io_addr   = io_sel ? (addr_q[7:0] - IO_BASE[7:0]) : 8'h00;
  assign bus.io_wdata  = (io_sel && op_write_q) ? wdata_q : 8'h00;

endmodule

// File: tb/tb_axioma_data_mem.sv
// tb/tb_axioma_data_mem.sv - scoreboard bench for axioma_data_mem at WAIT_STATES 1, 0 and 4
module tb_axioma_data_mem;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_clr = 1'b0;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Cycle index used for latency expectations
  always @(posedge clk) cyc <= cyc + 1;

  axioma_data_mem_if b1 ();
  axioma_data_mem_if b0 ();
  axioma_data_mem_if b4 ();

  logic busy1, eu1, eo1;
  logic busy0, eu0, eo0;
  logic busy4, eu4, eo4;

  axioma_data_mem #(.WAIT_STATES(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(b1), .busy(busy1),
    .err_clr(err_clr), .err_unmapped(eu1), .err_overrun(eo1));

  axioma_data_mem #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0), .busy(busy0),
    .err_clr(err_clr), .err_unmapped(eu0), .err_overrun(eo0));

  axioma_data_mem #(.WAIT_STATES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4), .busy(busy4),
    .err_clr(err_clr), .err_unmapped(eu4), .err_overrun(eo4));

  typedef struct {
    logic [7:0]  rdata;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } io_exp_t;

  exp_t    q1[$];
  exp_t    q0[$];
  exp_t    q4[$];
  io_exp_t qio[$];
  logic [7:0] last_rd [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy1;
      1:       return busy0;
      default: return busy4;
    endcase
  endfunction

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [7:0] wd);
    case (d)
      0: begin b1.mem_read = rd; b1.mem_write = wr; b1.mem_addr = a; b1.mem_wdata = wd; end
      1: begin b0.mem_read = rd; b0.mem_write = wr; b0.mem_addr = a; b0.mem_wdata = wd; end
      default: begin b4.mem_read = rd; b4.mem_write = wr; b4.mem_addr = a; b4.mem_wdata = wd; end
    endcase
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      0:       q1.push_back(e);
      1:       q0.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_of(d) && n < 32) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_timeout_dut%0d", d), 32'(busy_of(d)), 32'd0);
  endtask

  // One-cycle strobe; reads update the model's held read data, writes expect it unchanged
  task automatic txn(input int d, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [7:0] wd, input logic [7:0] rexp);
    exp_t e;
    @(posedge clk); #1;
    drive(d, rd, wr, a, wd);
    if (rd && !wr) last_rd[d] = rexp;
    e.rdata = last_rd[d];
    e.cyc   = cyc + 2 + ws_of(d);
    push(d, e);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, a, wd);
    wait_idle(d);
  endtask

  task automatic pop_check(input int d, input logic [7:0] rd);
    exp_t e;
    int   sz;
    case (d)
      0:       sz = q1.size();
      1:       sz = q0.size();
      default: sz = q4.size();
    endcase
    if (sz == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_ready_dut%0d: got ready with rdata %0h at cycle %0d, required none", d, rd, cyc);
    end else begin
      case (d)
        0:       e = q1.pop_front();
        1:       e = q0.pop_front();
        default: e = q4.pop_front();
      endcase
      chk($sformatf("rdata_dut%0d", d), 32'(rd), 32'(e.rdata));
      chk($sformatf("ready_cycle_dut%0d", d), cyc, e.cyc);
    end
  endtask

  task automatic io_check();
    io_exp_t e;
    if (qio.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_io_strobe: got rd=%0b wr=%0b addr=%0h, required none",
               b1.io_read, b1.io_write, b1.io_addr);
    end else begin
      e = qio.pop_front();
      chk("io_write", 32'(b1.io_write), 32'(e.wr));
      chk("io_read", 32'(b1.io_read), 32'(!e.wr));
      chk("io_addr", 32'(b1.io_addr), 32'(e.addr));
      if (e.wr) chk("io_wdata", 32'(b1.io_wdata), 32'(e.wdata));
    end
  endtask

  // Monitor: every presented response is matched against the scoreboard
  always @(negedge clk) begin
    if (b1.mem_ready === 1'b1) pop_check(0, b1.mem_rdata);
    if (b0.mem_ready === 1'b1) pop_check(1, b0.mem_rdata);
    if (b4.mem_ready === 1'b1) pop_check(2, b4.mem_rdata);
    if (b1.io_read || b1.io_write) io_check();
    if (b0.io_read || b0.io_write || b4.io_read || b4.io_write) begin
      n_checks++;
      n_fail++;
      $display("FAIL sweep_io_strobe: got an I/O strobe on a sweep instance, required none");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    io_exp_t ie;
    exp_t    e;

    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(2, 1'b0, 1'b0, 16'h0000, 8'h00);
    b1.io_rdata = 8'h00;
    b0.io_rdata = 8'h00;
    b4.io_rdata = 8'h00;
    for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(b1.mem_ready), 32'd0);
    chk("rst_rdata", 32'(b1.mem_rdata), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_io_strobes", 32'({b1.io_read, b1.io_write}), 32'd0);
    chk("rst_io_addr", 32'(b1.io_addr), 32'd0);
    chk("rst_io_wdata", 32'(b1.io_wdata), 32'd0);
    chk("rst_errs", 32'({eu1, eo1}), 32'd0);

    // SRAM first byte and last byte
    txn(0, 1'b0, 1'b1, 16'h0100, 8'hA5, 8'h00);
    txn(0, 1'b1, 1'b0, 16'h0100, 8'h00, 8'hA5);
    txn(0, 1'b0, 1'b1, 16'h08FF, 8'h3C, 8'h00);
    txn(0, 1'b1, 1'b0, 16'h08FF, 8'h00, 8'h3C);
    chk("err_unmapped_sram", 32'(eu1), 32'd0);

    // One past the end of SRAM
    txn(0, 1'b1, 1'b0, 16'h0900, 8'h00, 8'h00);
    chk("err_unmapped_0900", 32'(eu1), 32'd1);
    chk("err_overrun_clean", 32'(eo1), 32'd0);

    // I/O read and write
    b1.io_rdata = 8'h77;
    ie.wr = 1'b0; ie.addr = 8'h05; ie.wdata = 8'h00;
    qio.push_back(ie);
    txn(0, 1'b1, 1'b0, 16'h0025, 8'h00, 8'h77);
    b1.io_rdata = 8'h00;
    ie.wr = 1'b1; ie.addr = 8'h3F; ie.wdata = 8'h12;
    qio.push_back(ie);
    txn(0, 1'b0, 1'b1, 16'h005F, 8'h12, 8'h00);

    // Low unmapped hole below the I/O window
    txn(0, 1'b1, 1'b0, 16'h0010, 8'h00, 8'h00);

    // Second strobe during WAIT is ignored
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'h0100, 8'h00);
    last_rd[0] = 8'hA5;
    e.rdata = 8'hA5; e.cyc = cyc + 3;
    push(0, e);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0100, 8'h00);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 16'h0100, 8'hFF);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0100, 8'h00);
    wait_idle(0);
    chk("err_overrun_wait", 32'(eo1), 32'd1);
    chk("err_unmapped_kept", 32'(eu1), 32'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("err_clr_flags", 32'({eu1, eo1}), 32'd0);
    txn(0, 1'b1, 1'b0, 16'h0100, 8'h00, 8'hA5);

    // Read+write together: write lands; clear in the same cycle wins
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 16'h0101, 8'h5A);
    err_clr = 1'b1;
    e.rdata = last_rd[0]; e.cyc = cyc + 3;
    push(0, e);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0101, 8'h00);
    err_clr = 1'b0;
    wait_idle(0);
    chk("err_clr_priority", 32'(eo1), 32'd0);
    txn(0, 1'b1, 1'b1, 16'h0102, 8'h6B, 8'h00);
    chk("err_overrun_rw", 32'(eo1), 32'd1);
    txn(0, 1'b1, 1'b0, 16'h0101, 8'h00, 8'h5A);
    txn(0, 1'b1, 1'b0, 16'h0102, 8'h00, 8'h6B);

    // Reset during WAIT
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'h0100, 8'h00);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0100, 8'h00);
    @(posedge clk); #1;
    chk("busy_in_wait", 32'(busy1), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_ready", 32'(b1.mem_ready), 32'd0);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_io_strobes", 32'({b1.io_read, b1.io_write}), 32'd0);
    chk("abort_errs", 32'({eu1, eo1}), 32'd0);
    for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
    @(posedge clk); #1 reset_n = 1'b1;
    chk("abort_rdata", 32'(b1.mem_rdata), 32'd0);
    txn(0, 1'b1, 1'b0, 16'h0100, 8'h00, 8'hA5);

    // Latency sweep at WAIT_STATES 0 and 4
    txn(1, 1'b0, 1'b1, 16'h0200, 8'h11, 8'h00);
    txn(1, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h11);
    txn(2, 1'b0, 1'b1, 16'h07FF, 8'hC3, 8'h00);
    txn(2, 1'b1, 1'b0, 16'h07FF, 8'h00, 8'hC3);
    txn(2, 1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h00);
    chk("ws4_err_unmapped", 32'(eu4), 32'd1);
    chk("ws_errs_clean", 32'({eu0, eo0, eo4}), 32'd0);

    repeat (3) @(negedge clk);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);
    chk("qio_drained", qio.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
